// File: rtl/cmd_scheduler_pkg.sv
// ============================================================================
// cmd_scheduler_pkg : shared types for the DRAM command scheduler. Rev 1.0
// ============================================================================
`default_nettype none

package cmd_scheduler_pkg;

  typedef enum logic [1:0] {
    OPEN_PAGE_SAME_WE = 2'd0,
    OPEN_PAGE_DIF_WE  = 2'd1,
    CLOSED_PAGE       = 2'd2,
    CROSS_PAGE        = 2'd3
  } priority_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    ISSUE = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic       we;
    logic [2:0] row;
    logic [1:0] bank;
  } cmd_t;

  localparam int AGE_W = 3;

endpackage

`default_nettype wire

// File: rtl/cmd_scheduler_pick.sv
// ============================================================================
// cmd_pick : combinational read/write candidate selection. Rev 1.0
// ============================================================================
`default_nettype none

module cmd_pick
  import cmd_scheduler_pkg::*;
(
  input  logic       rd_valid,
  input  logic       wr_valid,
  input  logic [1:0] rd_bank,
  input  logic [1:0] wr_bank,
  input  logic [1:0] read_priority,
  input  logic [1:0] write_priority,
  input  logic [3:0] bank_ready,
  input  logic       rr,
  input  logic       rd_force,
  input  logic       wr_force,
  output logic       pick_valid,
  output logic       pick_we,
  output logic       pick_tie
);

  priority_t rd_grade;
  priority_t wr_grade;
  logic      rd_rdy;
  logic      wr_rdy;

  assign rd_grade = priority_t'(read_priority);
  assign wr_grade = priority_t'(write_priority);
  assign rd_rdy   = bank_ready[rd_bank];
  assign wr_rdy   = bank_ready[wr_bank];

  always_comb begin
    pick_valid = rd_valid | wr_valid;
    pick_we    = 1'b0;
    pick_tie   = 1'b0;
    if (rd_valid && wr_valid) begin
      if (wr_force) begin
        pick_we = 1'b1;
      end else if (rd_force) begin
        pick_we = 1'b0;
      end else if (wr_grade < rd_grade) begin
        pick_we = 1'b1;
      end else if (rd_grade < wr_grade) begin
        pick_we = 1'b0;
      end else if (wr_rdy && !rd_rdy) begin
        pick_we = 1'b1;
      end else if (rd_rdy && !wr_rdy) begin
        pick_we = 1'b0;
      end else begin
        // Only this fully tied case consumes the round-robin bit.
        pick_tie = 1'b1;
        pick_we  = rr;
      end
    end else if (wr_valid) begin
      pick_we = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cmd_scheduler.sv
// ============================================================================
// cmd_scheduler : grants one read/write pool head per command to the PHY.
// Optional starvation guard: STARVATION_GUARD_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module cmd_scheduler
  import cmd_scheduler_pkg::*;
#(
  parameter int TURNAROUND_CYCLES = 2
`ifdef STARVATION_GUARD_EN
  , parameter int MAX_AGE = 7
`endif
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rd_valid,
  input  logic [2:0] rd_row,
  input  logic [1:0] rd_bank,
  input  logic       wr_valid,
  input  logic [2:0] wr_row,
  input  logic [1:0] wr_bank,
  input  logic [1:0] read_priority,
  input  logic [1:0] write_priority,
  input  logic [3:0] bank_ready,
  input  logic       cmd_ready,
  output logic       rd_pop,
  output logic       wr_pop,
  output logic       cmd_valid,
  output logic       cmd_we,
  output logic [2:0] cmd_row,
  output logic [1:0] cmd_bank,
  output logic       read_issued,
  output logic       write_issued,
  output logic [2:0] last_row,
  output logic [1:0] last_bank
);

  localparam int CNT_W = (TURNAROUND_CYCLES > 2) ? $clog2(TURNAROUND_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (TURNAROUND_CYCLES > 0) ? CNT_W'(TURNAROUND_CYCLES - 1) : '0;
  localparam logic TURN_EN = (TURNAROUND_CYCLES != 0);

  sched_state_t     state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [2:0]       last_row_q, last_row_d;
  logic [1:0]       last_bank_q, last_bank_d;
  logic             last_we_q, last_we_d;
  logic             rr_q, rr_d;
  logic             turned_q, turned_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic pick_valid, pick_we, pick_tie;
  logic rd_force, wr_force;
  logic grant_ok, handshake;

  cmd_pick u_pick (
    .rd_valid       (rd_valid),
    .wr_valid       (wr_valid),
    .rd_bank        (rd_bank),
    .wr_bank        (wr_bank),
    .read_priority  (read_priority),
    .write_priority (write_priority),
    .bank_ready     (bank_ready),
    .rr             (rr_q),
    .rd_force       (rd_force),
    .wr_force       (wr_force),
    .pick_valid     (pick_valid),
    .pick_we        (pick_we),
    .pick_tie       (pick_tie)
  );

  assign grant_ok  = !TURN_EN || turned_q || (pick_we == last_we_q);
  assign handshake = (state_q == ISSUE) && cmd_ready;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    last_row_d  = last_row_q;
    last_bank_d = last_bank_q;
    last_we_d   = last_we_q;
    rr_d        = rr_q;
    turned_d    = turned_q;
    cnt_d       = cnt_q;
    rd_pop      = 1'b0;
    wr_pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          if (grant_ok) begin
            rd_pop   = ~pick_we;
            wr_pop   = pick_we;
            cmd_d.we = pick_we;
            cmd_d.row  = pick_we ? wr_row  : rd_row;
            cmd_d.bank = pick_we ? wr_bank : rd_bank;
            turned_d = 1'b0;
            if (pick_tie) rr_d = ~rr_q;
            state_d  = ISSUE;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = TURN;
          end
        end
      end
      TURN: begin
        if (cnt_q == '0) begin
          turned_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          last_row_d  = cmd_q.row;
          last_bank_d = cmd_q.bank;
          last_we_d   = cmd_q.we;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      last_row_q  <= '0;
      last_bank_q <= '0;
      last_we_q   <= 1'b0;
      rr_q        <= 1'b0;
      turned_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      last_row_q  <= last_row_d;
      last_bank_q <= last_bank_d;
      last_we_q   <= last_we_d;
      rr_q        <= rr_d;
      turned_q    <= turned_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef STARVATION_GUARD_EN
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(MAX_AGE);
  localparam logic [AGE_W-1:0] AGE_SAT   = {AGE_W{1'b1}};

  logic [AGE_W-1:0] rd_age_q, rd_age_d;
  logic [AGE_W-1:0] wr_age_q, wr_age_d;

  always_comb begin
    rd_age_d = rd_age_q;
    wr_age_d = wr_age_q;
    if (!rd_valid || rd_pop) rd_age_d = '0;
    else if (wr_pop && rd_age_q != AGE_SAT) rd_age_d = rd_age_q + 1'b1;
    if (!wr_valid || wr_pop) wr_age_d = '0;
    else if (rd_pop && wr_age_q != AGE_SAT) wr_age_d = wr_age_q + 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_age_q <= '0;
      wr_age_q <= '0;
    end else begin
      rd_age_q <= rd_age_d;
      wr_age_q <= wr_age_d;
    end
  end

  assign rd_force = (rd_age_q >= AGE_LIMIT);
  assign wr_force = (wr_age_q >= AGE_LIMIT);
`else
  assign rd_force = 1'b0;
  assign wr_force = 1'b0;
`endif

  assign cmd_valid    = (state_q == ISSUE);
  assign cmd_we       = cmd_q.we;
  assign cmd_row      = cmd_q.row;
  assign cmd_bank     = cmd_q.bank;
  assign read_issued  = handshake & ~cmd_q.we;
  assign write_issued = handshake & cmd_q.we;
  assign last_row     = last_row_q;
  assign last_bank    = last_bank_q;

endmodule

`default_nettype wire

// File: tb/tb_cmd_scheduler.sv
// ============================================================================
// tb_cmd_scheduler : directed scoreboard bench for cmd_scheduler. Rev 1.0
// ============================================================================
`default_nettype none

module tb_cmd_scheduler;
  import cmd_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       rd_valid, wr_valid, cmd_ready;
  logic [2:0] rd_row, wr_row;
  logic [1:0] rd_bank, wr_bank;
  logic [1:0] read_priority, write_priority;
  logic [3:0] bank_ready;
  logic       rd_pop, wr_pop, cmd_valid, cmd_we;
  logic [2:0] cmd_row, last_row;
  logic [1:0] cmd_bank, last_bank;
  logic       read_issued, write_issued;

  int   checks = 0;
  int   errors = 0;
  cmd_t sb[$];

  cmd_scheduler dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .rd_valid       (rd_valid),
    .rd_row         (rd_row),
    .rd_bank        (rd_bank),
    .wr_valid       (wr_valid),
    .wr_row         (wr_row),
    .wr_bank        (wr_bank),
    .read_priority  (read_priority),
    .write_priority (write_priority),
    .bank_ready     (bank_ready),
    .cmd_ready      (cmd_ready),
    .rd_pop         (rd_pop),
    .wr_pop         (wr_pop),
    .cmd_valid      (cmd_valid),
    .cmd_we         (cmd_we),
    .cmd_row        (cmd_row),
    .cmd_bank       (cmd_bank),
    .read_issued    (read_issued),
    .write_issued   (write_issued),
    .last_row       (last_row),
    .last_bank      (last_bank)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Optional turnaround (IDLE + 2 TURN cycles with no pops), then the grant pulse.
  task automatic grant(input logic we, input logic turn);
    cmd_t e;
    if (turn) begin
      for (int i = 0; i < 3; i++) begin
        #1;
        chk1("turn_rd_pop", rd_pop, 1'b0);
        chk1("turn_wr_pop", wr_pop, 1'b0);
        chk1("turn_cmd_valid", cmd_valid, 1'b0);
        tick();
      end
    end
    #1;
    chk1("grant_rd_pop", rd_pop, ~we);
    chk1("grant_wr_pop", wr_pop, we);
    e.we   = we;
    e.row  = we ? wr_row  : rd_row;
    e.bank = we ? wr_bank : rd_bank;
    sb.push_back(e);
    tick();
  endtask

  task automatic issue();
    cmd_t e;
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=0 expected=entry");
    end else begin
      e = sb.pop_front();
      chk1("iss_cmd_valid", cmd_valid, 1'b1);
      chk1("iss_cmd_we", cmd_we, e.we);
      chk3("iss_cmd_row", cmd_row, e.row);
      chk3("iss_cmd_bank", {1'b0, cmd_bank}, {1'b0, e.bank});
      chk1("iss_read_issued", read_issued, ~e.we);
      chk1("iss_write_issued", write_issued, e.we);
      chk1("iss_rd_pop", rd_pop, 1'b0);
      chk1("iss_wr_pop", wr_pop, 1'b0);
      tick();
      #1;
      chk3("last_row", last_row, e.row);
      chk3("last_bank", {1'b0, last_bank}, {1'b0, e.bank});
      chk1("post_cmd_valid", cmd_valid, 1'b0);
    end
  endtask

  initial begin
    n_rst = 1'b0;
    rd_valid = 1'b0; wr_valid = 1'b0; cmd_ready = 1'b1;
    rd_row = '0; wr_row = '0; rd_bank = '0; wr_bank = '0;
    read_priority = '0; write_priority = '0; bank_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_cmd_valid", cmd_valid, 1'b0);
    chk1("rst_cmd_we", cmd_we, 1'b0);
    chk3("rst_cmd_row", cmd_row, 3'd0);
    chk3("rst_last_row", last_row, 3'd0);
    chk3("rst_last_bank", {1'b0, last_bank}, 3'd0);
    n_rst = 1'b1;
    tick();
    #1;
    chk1("idle_rd_pop", rd_pop, 1'b0);
    chk1("idle_wr_pop", wr_pop, 1'b0);

    // Same-direction read wins on priority.
    rd_valid = 1'b1; rd_row = 3'd5; rd_bank = 2'd2;
    wr_valid = 1'b1; wr_row = 3'd3; wr_bank = 2'd1;
    read_priority = 2'd0; write_priority = 2'd2;
    grant(1'b0, 1'b0);
    rd_valid = 1'b0; wr_valid = 1'b0;
    issue();

    // Write alone after a read: turnaround first.
    wr_valid = 1'b1; wr_row = 3'd6; wr_bank = 2'd3; write_priority = 2'd1;
    grant(1'b1, 1'b1);
    wr_valid = 1'b0;
    issue();

    // Equal grades: bank_ready picks write.
    rd_valid = 1'b1; wr_valid = 1'b1; read_priority = 2'd2; write_priority = 2'd2;
    bank_ready = 4'b0010; wr_bank = 2'd1; rd_bank = 2'd3; rd_row = 3'd2; wr_row = 3'd4;
    grant(1'b1, 1'b0);
    issue();

    // Full ties alternate through rr, each with a turnaround.
    bank_ready = 4'b0000; rd_row = 3'd1;
    grant(1'b0, 1'b1);
    issue();
    wr_row = 3'd7;
    grant(1'b1, 1'b1);
    issue();
    rd_row = 3'd3;
    grant(1'b0, 1'b1);
    issue();

    // Backpressure: command held while heads change.
    read_priority = 2'd0; write_priority = 2'd3; rd_row = 3'd4; rd_bank = 2'd1;
    grant(1'b0, 1'b0);
    cmd_ready = 1'b0;
    rd_row = 3'd6; rd_bank = 2'd0; wr_row = 3'd5;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk1("bp_cmd_valid", cmd_valid, 1'b1);
      chk3("bp_cmd_row", cmd_row, 3'd4);
      chk3("bp_cmd_bank", {1'b0, cmd_bank}, 3'd1);
      chk1("bp_rd_pop", rd_pop, 1'b0);
      chk1("bp_wr_pop", wr_pop, 1'b0);
      chk1("bp_read_issued", read_issued, 1'b0);
      tick();
    end
    cmd_ready = 1'b1;
    issue();

    // Reset while a write is held in ISSUE.
    rd_valid = 1'b0; wr_row = 3'd2; wr_bank = 2'd0;
    grant(1'b1, 1'b1);
    cmd_ready = 1'b0;
    #1;
    chk1("pre_rst_cmd_valid", cmd_valid, 1'b1);
    #1;
    n_rst = 1'b0;
    #1;
    chk1("midrst_cmd_valid", cmd_valid, 1'b0);
    chk3("midrst_last_row", last_row, 3'd0);
    chk3("midrst_last_bank", {1'b0, last_bank}, 3'd0);
    chk3("midrst_cmd_row", cmd_row, 3'd0);
    void'(sb.pop_back());
    cmd_ready = 1'b1;
    tick();
    n_rst = 1'b1;
    // last_we is back to read, so the waiting write needs a turnaround.
    grant(1'b1, 1'b1);
    issue();

    rd_valid = 1'b1; wr_valid = 1'b1; read_priority = 2'd0; write_priority = 2'd3;
    rd_row = 3'd1; rd_bank = 2'd1; wr_row = 3'd7; wr_bank = 2'd2;
    for (int i = 0; i < 7; i++) begin
      grant(1'b0, (i == 0));
      issue();
    end
`ifdef STARVATION_GUARD_EN
    grant(1'b1, 1'b1);
    issue();
`else
    grant(1'b0, 1'b0);
    issue();
`endif

    rd_valid = 1'b0; wr_valid = 1'b0;
    tick();
    #1;
    chk1("end_rd_pop", rd_pop, 1'b0);
    chk1("end_wr_pop", wr_pop, 1'b0);
    chk1("end_cmd_valid", cmd_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
